fetch_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage pipeline. Consumes the `stall` and `flush` outputs of the hazard unit, plus the EX-stage branch target.
- Owns the fetch PC, the instruction-memory request/response handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Drives `pc_ID`, `pc4_ID`, `instr_ID` and `valid_ID` into the decode stage.
- Supports one outstanding memory request, pipelined back-to-back, for up to 1 instruction/cycle.

---
 rtl/fetch_pkg.sv | 40 ++++
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage
//               and the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int unsigned     PKG_XLEN  = 32;
    localparam logic [31:0]     RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] pc4;
        logic [31:0]         instr;
        logic                valid;
    } if_id_t;

    // Squashed slot presented to decode after reset or a redirect.
    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc    = '0;
        b.pc4   = PKG_XLEN'(4);
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, clear and synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  fetch_pkg::if_id_t d_i,
    output fetch_pkg::if_id_t q_o
);
    import fetch_pkg::*;

    if_id_t slot_q;

    // Clear outranks hold so a redirect squashes a stalled slot.
    // Without a new instruction the slot turns into a bubble.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            slot_q <= if_id_bubble(NOP_INSTR);
        end else if (!hold_i) begin
            if (load_i) begin
                slot_q <= d_i;
            end else begin
                slot_q.valid <= 1'b0;
            end
        end
    end

    assign q_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end: fetch PC, single-outstanding
//               imem handshake, one-entry skid buffer and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int unsigned      XLEN      = fetch_pkg::PKG_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = fetch_pkg::RESET_PC,
    parameter logic [31:0]      NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] btarget_EX,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_ID,
    output logic [XLEN-1:0] pc4_ID,
    output logic [31:0]     instr_ID,
    output logic            valid_ID
);
    import fetch_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            drop_q, drop_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_instr_q, buf_instr_d;

    logic            req;
    logic            ifid_load;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= REQ;
            pc_f_q        <= RESET_PC;
            pc_inflight_q <= RESET_PC;
            drop_q        <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_pc_q      <= '0;
            buf_instr_q   <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            pc_inflight_q <= pc_inflight_d;
            drop_q        <= drop_d;
            buf_valid_q   <= buf_valid_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        pc_inflight_d = pc_inflight_q;
        drop_d        = drop_q;
        buf_valid_d   = buf_valid_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        req           = 1'b0;
        ifid_load     = 1'b0;
        ifid_d.pc     = pc_inflight_q;
        ifid_d.pc4    = pc_inflight_q + PC_STEP;
        ifid_d.instr  = imem_rdata;
        ifid_d.valid  = 1'b1;

        case (state_q)
            REQ: begin
                // Prefetch continues under stall; only a redirect blocks it.
                req = !flush;
                if (req && imem_ready) begin
                    pc_inflight_d = pc_f_q;
                    pc_f_d        = pc_f_q + PC_STEP;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // Issue the next fetch in the response cycle for 1 instr/cycle.
                req = imem_rvalid && !stall && !flush && !drop_q;
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (stall) begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = pc_inflight_q;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        if (req && imem_ready) begin
                            pc_inflight_d = pc_f_q;
                            pc_f_d        = pc_f_q + PC_STEP;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    if (buf_valid_q) begin
                        ifid_load    = 1'b1;
                        ifid_d.pc    = buf_pc_q;
                        ifid_d.pc4   = buf_pc_q + PC_STEP;
                        ifid_d.instr = buf_instr_q;
                    end
                    buf_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // Redirect overrides everything; an outstanding fetch must be dropped.
        if (flush) begin
            pc_f_d      = btarget_EX;
            buf_valid_d = 1'b0;
            ifid_load   = 1'b0;
            if (state_q == WAIT && !imem_rvalid) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = REQ;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .hold_i  (stall),
        .clear_i (flush),
        .load_i  (ifid_load),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign imem_req  = req;
    assign imem_addr = pc_f_q;
    assign pc_ID     = ifid_q.pc;
    assign pc4_ID    = ifid_q.pc4;
    assign instr_ID  = ifid_q.instr;
    assign valid_ID  = ifid_q.valid;

`ifndef SYNTHESIS
    logic post_rst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            post_rst_q <= 1'b1;
        end else if (req && imem_ready) begin
            post_rst_q <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rvalid && state_q != WAIT && !post_rst_q))
                else $error("imem_rvalid without an outstanding request");
            assert (!(req && state_q == HOLD))
                else $error("imem_req asserted while holding");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed bench for fetch_stage with a memory model and an
//               in-order scoreboard of fetched addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] btarget;
    logic        imem_req, imem_ready, imem_rvalid, valid_ID;
    logic [31:0] imem_addr, imem_rdata, pc_ID, pc4_ID, instr_ID;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic        pend_v;
    logic [31:0] pend_a;
    int          pend_cnt;
    int          lat;
    logic        last_valid;
    logic [31:0] last_pc;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .btarget_EX  (btarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_ID       (pc_ID),
        .pc4_ID      (pc4_ID),
        .instr_ID    (instr_ID),
        .valid_ID    (valid_ID)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then score and drive memory.
    task automatic tick();
        logic        acc, rv, stl, fl, rs;
        logic [31:0] acc_a, e;
        @(negedge clk);
        acc   = imem_req && imem_ready;
        acc_a = imem_addr;
        rv    = imem_rvalid;
        stl   = stall;
        fl    = flush;
        rs    = reset;
        @(posedge clk);
        #1;
        if (rs) begin
            pend_v     = 1'b0;
            sb.delete();
            last_valid = 1'b0;
            last_pc    = '0;
        end else begin
            if (rv) pend_v = 1'b0;
            if (fl) begin
                sb.delete();
                last_valid = 1'b0;
                last_pc    = '0;
            end
            if (acc) begin
                pend_v   = 1'b1;
                pend_a   = acc_a;
                pend_cnt = lat;
                sb.push_back(acc_a);
            end
            if (!fl && stl) begin
                chk("hold_valid", 32'(valid_ID), 32'(last_valid));
                if (last_valid) chk("hold_pc", pc_ID, last_pc);
            end else if (!fl && valid_ID) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(valid_ID), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", pc_ID, e);
                    chk("id_pc4", pc4_ID, e + 32'd4);
                    chk("id_instr", instr_ID, e ^ KEY);
                    last_valid = 1'b1;
                    last_pc    = e;
                end
            end else if (!fl) begin
                last_valid = 1'b0;
            end
        end
        if (pend_v && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_a ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (pend_v) pend_cnt--;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc_ID, 32'h0);
        chk({tag, "_pc4"},   pc4_ID, 32'h4);
        chk({tag, "_instr"}, instr_ID, NOP);
        chk({tag, "_valid"}, 32'(valid_ID), 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; btarget = '0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        pend_v = 1'b0; pend_a = '0; pend_cnt = 0; lat = 0;
        last_valid = 1'b0; last_pc = '0;

        repeat (2) tick();
        #1 chk_reset_vals("rst");
        reset = 1'b0;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        tick(); #1 chk("c1_addr", imem_addr, 32'h4);
        tick(); #1 chk("c2_addr", imem_addr, 32'h8);
        chk("c2_valid", 32'(valid_ID), 32'd1);
        tick();

        // Stall three cycles while the response for 0x8 arrives.
        stall = 1'b1;
        #1 chk("stall_req", 32'(imem_req), 32'd0);
        repeat (3) tick();
        stall = 1'b0;
        #1 chk("hold_req", 32'(imem_req), 32'd0);
        tick();
        #1 chk("unstall_pc", pc_ID, 32'h8);
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'hC);
        tick();

        // Flush while the fetch of 0x10 is outstanding; its response comes late.
        lat = 2;
        tick();
        flush = 1'b1; btarget = 32'h100;
        #1 chk("flush_req", 32'(imem_req), 32'd0);
        tick();
        flush = 1'b0; lat = 0;
        #1;
        chk("flush_valid", 32'(valid_ID), 32'd0);
        chk("flush_instr", instr_ID, NOP);
        chk("flush_addr", imem_addr, 32'h100);
        chk("drop_req0", 32'(imem_req), 32'd0);
        tick();
        #1 chk("drop_req1", 32'(imem_req), 32'd0);
        tick();
        #1 chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        tick();
        #1 chk("redir_pc", pc_ID, 32'h100);
        chk("redir_instr", instr_ID, 32'h100 ^ KEY);

        // Simultaneous stall and flush: flush wins, nothing is parked.
        stall = 1'b1; flush = 1'b1; btarget = 32'h40;
        tick();
        stall = 1'b0;
        #1 chk("sf_valid", 32'(valid_ID), 32'd0);
        chk("sf_addr", imem_addr, 32'h40);

        // Redirect to 0x20 from REQ, then hold ready low.
        btarget = 32'h20; imem_ready = 1'b0;
        #1 chk("freq_req", 32'(imem_req), 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("nrdy_req", 32'(imem_req), 32'd1);
            chk("nrdy_addr", imem_addr, 32'h20);
            tick();
        end
        imem_ready = 1'b1;
        #1 chk("rdy_addr", imem_addr, 32'h20);
        tick();
        #1 chk("acc_addr", imem_addr, 32'h24);
        repeat (3) tick();

        // Address wrap at the top of the address space.
        flush = 1'b1; btarget = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        #1 chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        #1 chk("wrap_addr", imem_addr, 32'h0);
        tick();
        #1 chk("wrap_pc4", pc4_ID, 32'h0);

        // Reset in the middle of a transaction.
        reset = 1'b1;
        tick();
        #1 chk_reset_vals("mid_rst");
        reset = 1'b0;
        repeat (3) tick();
        #1 chk("post_rst_pc", pc_ID, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
